// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and defaults for the memory arbiter
package mem_arb_pkg;

    // Tag of what was issued to memory in the previous cycle; selects the
    // read-return path in the current cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        D_RD  = 2'd2,
        D_WR  = 2'd3
    } arb_state_t;

    localparam int DEFAULT_STARVE_LIMIT = 3;

    // Bits needed to count 0..limit inclusive, never less than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// rtl/mem_arbiter_starve_counter.sv - saturating denial counter with clear and at-limit flag
module starve_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int W     = cnt_width(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    // Count consecutive denials, holding at LIM; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int AW           = 16,
    parameter int DW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if
);

    arb_state_t state;
    logic       at_limit;
    logic       fetch_wins;

    // Data normally outranks fetch; a fetch that has been denied long enough
    // takes the port even against a pending data request.
    assign fetch_wins = if_req & (at_limit | ~d_req);

    // Grants are combinational and forced low while reset is held so that
    // every output reads zero during reset.
    assign if_gnt   = ~rst & fetch_wins;
    assign d_gnt    = ~rst & d_req & ~fetch_wins;
    assign stall_if = ~rst & if_req & ~if_gnt;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (if_req & ~if_gnt),
        .clr      (if_gnt | ~if_req),
        .at_limit (at_limit)
    );

    // Drive the memory port from whichever requester holds the grant.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Remember what was issued this cycle so next cycle's read data is steered
    // to the right requester; reset drops any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (if_gnt) begin
            state <= IF_RD;
        end else if (d_gnt && !d_we) begin
            state <= D_RD;
        end else if (d_gnt && d_we) begin
            state <= D_WR;
        end else begin
            state <= IDLE;
        end
    end

    // Return path: memory data passes through only to the requester whose
    // read was issued last cycle; stores complete at issue and return nothing.
    assign if_rvalid = (state == IF_RD);
    assign d_rvalid  = (state == D_RD);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule
